rect_fill_engine: RTL

//   Parametrised rectangle fill engine for the VGA pixel path. On a start

---
 rtl/rect_fill_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: walks a clipped rectangle (or the whole screen in
// clear mode) in raster order. It presents one pixel per cycle on x/y/color
// and respects downstream backpressure.
//
// Handshake: plot is the valid signal and ready is the downstream accept.
// A pixel transfers on a rising edge where plot && ready are both high.
// While plot && !ready, x/y/color hold. plot never depends combinationally
// on ready.
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOR_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     h,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               ready,
  output logic               plot,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Screen limits widened by one bit so coordinate sums never wrap.
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t         state, state_next;
  logic [X_W-1:0] xs;
  logic [X_W:0]   xe;
  logic [Y_W:0]   ye;

  logic [X_W:0]   x_sum, xe_clip, x_inc;
  logic [Y_W:0]   y_sum, ye_clip, y_inc;
  logic           empty, row_end, last_pix;

  // Bounds for a new request and raster-walk decisions for the current pixel.
  always_comb begin
    x_sum    = {1'b0, x0} + {1'b0, w};
    y_sum    = {1'b0, y0} + {1'b0, h};
    xe_clip  = (x_sum > SCR_W) ? SCR_W : x_sum;
    ye_clip  = (y_sum > SCR_H) ? SCR_H : y_sum;
    empty    = !clear && ((w == '0) || (h == '0) ||
                          ({1'b0, x0} >= SCR_W) || ({1'b0, y0} >= SCR_H));
    x_inc    = {1'b0, x} + 1'b1;
    y_inc    = {1'b0, y} + 1'b1;
    row_end  = (x_inc >= xe);
    last_pix = row_end && (y_inc >= ye);
  end

  // Next-state logic: IDLE -> FILL -> DONE -> IDLE. An empty request skips FILL.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = empty ? DONE : FILL;
      FILL:    if (ready && last_pix) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus the coordinate walker and the latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      color <= '0;
      xs    <= '0;
      xe    <= '0;
      ye    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            color <= color_in;
            if (clear) begin
              xs <= '0;
              x  <= '0;
              y  <= '0;
              xe <= SCR_W;
              ye <= SCR_H;
            end else if (!empty) begin
              xs <= x0;
              x  <= x0;
              y  <= y0;
              xe <= xe_clip;
              ye <= ye_clip;
            end
          end
        end
        FILL: begin
          // Coordinates freeze on the last pixel so they stay visible through DONE.
          if (ready && !last_pix) begin
            if (row_end) begin
              x <= xs;
              y <= y_inc[Y_W-1:0];
            end else begin
              x <= x_inc[X_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs are decoded straight from the state register.
  always_comb begin
    plot      = (state == FILL);
    busy      = (state == FILL);
    done      = (state == DONE);
    dbg_state = state;
  end

endmodule
